// File: rtl/serial_in_shift_register_pkg.sv
// mult_pkg: shared multiplier constants, clog2 helper and holding-register state encoding.
package mult_pkg;
  localparam int WIDTH_DEF = 4;
  localparam logic EMPTY = 1'b0;
  localparam logic FULL = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/serial_in_shift_register_if.sv
// serial_in_shift_register_if: serial input strobe/data plus parallel word handshake.
interface serial_in_shift_register_if #(parameter int WIDTH = mult_pkg::WIDTH_DEF);
  localparam int CW = mult_pkg::clog2(WIDTH + 1);
  logic shb;
  logic bit_in;
  logic abort;
  logic data_ack;
  logic [WIDTH-1:0] data_out;
  logic data_valid;
  logic [CW-1:0] bit_cnt;
  logic overrun;
  modport master (output shb, bit_in, abort, data_ack, input data_out, data_valid, bit_cnt, overrun);
  modport slave (input shb, bit_in, abort, data_ack, output data_out, data_valid, bit_cnt, overrun);
endinterface

// File: rtl/serial_in_shift_register_bit_counter.sv
// bit_counter: modulo-MOD up-counter with increment, sync clear and terminal flag at MOD-1.
module bit_counter #(
  parameter int MOD = 4,
  parameter int CW = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clear,
  output logic [CW-1:0] cnt,
  output logic term
);
  logic [CW-1:0] cnt_q, cnt_d;
  assign term = (cnt_q == CW'(MOD - 1));
  assign cnt = cnt_q;
  always_comb cnt_d = clear ? '0 : inc ? (term ? '0 : cnt_q + CW'(1)) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/serial_in_shift_register.sv
// serial_in_shift_register: LSB-first serial-to-parallel receiver with double-buffered word output.
// Define SIR_OVERRUN_EN to build the sticky overrun detector; otherwise overrun is tied to 0.
module serial_in_shift_register
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk,
  input logic clr,
  serial_in_shift_register_if.slave bus
);
  localparam int CW = clog2(WIDTH + 1);
  logic [WIDTH-1:0] shreg_q, shreg_d, data_q, data_d, word;
  logic state_q, state_d;
  logic [CW-1:0] cnt;
  logic term, shift, complete;
  assign shift = bus.shb & ~bus.abort;
  assign complete = shift & term;
  assign word = {bus.bit_in, shreg_q[WIDTH-1:1]};
  bit_counter #(.MOD(WIDTH), .CW(CW)) u_cnt (
    .clk(clk), .rst(clr), .inc(shift), .clear(bus.abort), .cnt(cnt), .term(term)
  );
  always_comb begin
    shreg_d = (bus.abort | complete) ? '0 : shift ? word : shreg_q;
    data_d = complete ? word : data_q;
    state_d = complete ? FULL : (state_q == FULL && bus.data_ack) ? EMPTY : state_q;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      shreg_q <= '0;
      data_q <= '0;
      state_q <= EMPTY;
    end else begin
      shreg_q <= shreg_d;
      data_q <= data_d;
      state_q <= state_d;
    end
  assign bus.data_out = data_q;
  assign bus.data_valid = (state_q == FULL);
  assign bus.bit_cnt = cnt;
`ifdef SIR_OVERRUN_EN
  logic overrun_q, overrun_d;
  always_comb overrun_d = overrun_q | (complete & (state_q == FULL) & ~bus.data_ack);
  always_ff @(posedge clk or posedge clr)
    if (clr) overrun_q <= 1'b0;
    else overrun_q <= overrun_d;
  assign bus.overrun = overrun_q;
`else
  assign bus.overrun = 1'b0;
`endif
endmodule

// File: tb/tb_serial_in_shift_register.sv
// tb_serial_in_shift_register: directed vector table plus async-clear and loopback sequences.
module tb_serial_in_shift_register;
`ifdef SIR_OVERRUN_EN
  localparam logic OV = 1'b1;
`else
  localparam logic OV = 1'b0;
`endif
  typedef struct packed {
    logic rst, shb, bit_in, abort, ack;
    logic [3:0] d;
    logic v;
    logic [2:0] c;
    logic o;
  } vec_t;
  logic clk = 0, clr = 0;
  int n_vec = 0, n_bad = 0;
  vec_t tbl[$];
  serial_in_shift_register_if #(.WIDTH(4)) bus();
  serial_in_shift_register #(.WIDTH(4)) dut (.clk(clk), .clr(clr), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic check_all(input string tag, input logic [3:0] d, input logic v, input logic [2:0] c, input logic o);
    check({tag, ".data_out"}, int'(bus.data_out), int'(d));
    check({tag, ".data_valid"}, int'(bus.data_valid), int'(v));
    check({tag, ".bit_cnt"}, int'(bus.bit_cnt), int'(c));
    check({tag, ".overrun"}, int'(bus.overrun), int'(o));
  endtask
  task automatic drive(input logic s, input logic b, input logic a, input logic k);
    @(negedge clk);
    bus.shb = s; bus.bit_in = b; bus.abort = a; bus.data_ack = k;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [3:0] pisr;
    bus.shb = 0; bus.bit_in = 0; bus.abort = 0; bus.data_ack = 0;
    //         rst shb bit abt ack  d      v  c  o
    tbl = '{
      '{1, 0, 0, 0, 0, 4'h0, 0, 0, 0},
      '{0, 1, 1, 0, 0, 4'h0, 0, 1, 0},
      '{0, 1, 1, 0, 0, 4'h0, 0, 2, 0},
      '{0, 1, 0, 0, 0, 4'h0, 0, 3, 0},
      '{0, 1, 1, 0, 0, 4'hB, 1, 0, 0},
      '{0, 1, 0, 0, 0, 4'hB, 1, 1, 0},
      '{0, 1, 1, 0, 0, 4'hB, 1, 2, 0},
      '{0, 1, 1, 0, 0, 4'hB, 1, 3, 0},
      '{0, 1, 0, 0, 0, 4'h6, 1, 0, OV},
      '{0, 0, 1, 0, 1, 4'h6, 0, 0, OV},
      '{0, 0, 0, 0, 1, 4'h6, 0, 0, OV},
      '{1, 0, 0, 0, 0, 4'h0, 0, 0, 0},
      '{0, 1, 1, 0, 0, 4'h0, 0, 1, 0},
      '{0, 1, 1, 0, 0, 4'h0, 0, 2, 0},
      '{0, 1, 1, 0, 0, 4'h0, 0, 3, 0},
      '{0, 1, 1, 0, 0, 4'hF, 1, 0, 0},
      '{0, 1, 1, 0, 0, 4'hF, 1, 1, 0},
      '{0, 1, 0, 0, 0, 4'hF, 1, 2, 0},
      '{0, 1, 1, 0, 0, 4'hF, 1, 3, 0},
      '{0, 1, 0, 0, 1, 4'h5, 1, 0, 0},
      '{0, 0, 0, 0, 1, 4'h5, 0, 0, 0},
      '{0, 1, 1, 0, 0, 4'h5, 0, 1, 0},
      '{0, 0, 1, 0, 0, 4'h5, 0, 1, 0},
      '{0, 1, 1, 0, 0, 4'h5, 0, 2, 0},
      '{0, 1, 1, 1, 0, 4'h5, 0, 0, 0},
      '{0, 1, 0, 0, 0, 4'h5, 0, 1, 0},
      '{0, 1, 0, 0, 0, 4'h5, 0, 2, 0},
      '{0, 1, 1, 0, 0, 4'h5, 0, 3, 0},
      '{0, 1, 0, 0, 0, 4'h4, 1, 0, 0},
      '{0, 0, 0, 0, 0, 4'h4, 1, 0, 0},
      '{0, 1, 1, 0, 0, 4'h4, 1, 1, 0},
      '{0, 0, 0, 1, 1, 4'h4, 0, 0, 0}
    };
    foreach (tbl[i]) begin
      @(negedge clk);
      clr = tbl[i].rst;
      bus.shb = tbl[i].shb; bus.bit_in = tbl[i].bit_in;
      bus.abort = tbl[i].abort; bus.data_ack = tbl[i].ack;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].d, tbl[i].v, tbl[i].c, tbl[i].o);
      clr = 0;
    end
    // build a pending word plus a partial one, then clear asynchronously mid-cycle
    drive(1, 1, 0, 0); drive(1, 0, 0, 0); drive(1, 1, 0, 0); drive(1, 1, 0, 0);
    drive(1, 1, 0, 0); drive(1, 1, 0, 0);
    check_all("pre_clr", 4'hD, 1, 2, 0);
    bus.shb = 0;
    #2 clr = 1;
    #1 check_all("async_clr", 4'h0, 0, 0, 0);
    @(negedge clk);
    clr = 0;
    // loopback from a right-shift register loaded with 4'b1011
    pisr = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.shb = 1; bus.bit_in = pisr[0];
      @(posedge clk);
      pisr = pisr >> 1;
      #1;
    end
    @(negedge clk);
    bus.shb = 0;
    check_all("loopback", 4'hB, 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
